// File: rtl/hazard_pause_ctrl_pkg.sv
// Shared constants and the pause-mode encoding for the hazard/pause controller.
// The mode encoding is used internally and is kept visible for debug probing.
package hazard_pause_ctrl_pkg;

    localparam logic PAUSE_ENABLE   = 1'b1;
    localparam logic PAUSE_DISABLE  = 1'b0;
    localparam int   DEFAULT_ADDR_W = 3;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_LOAD_USE = 2'd1,
        MODE_FLUSH    = 2'd2,
        MODE_BUSY     = 2'd3
    } pause_mode_t;

endpackage

// File: rtl/hazard_pause_ctrl_load_scoreboard.sv
// Countdown scoreboard of in-flight loads: flags operand hits against pending
// destinations and reports when a new load would find no free entry.
module load_scoreboard
    import hazard_pause_ctrl_pkg::*;
#(
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int NSRC     = 2,
    parameter int LOAD_LAT = 1,
    parameter int DEPTH    = 2,
    parameter int ZERO_HW  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   advance,
    input  logic                   alloc_en,
    input  logic                   req_valid,
    input  logic [ADDR_W-1:0]      wb_addr,
    input  logic [NSRC*ADDR_W-1:0] src_addr,
    input  logic [NSRC-1:0]        src_use,
    output logic                   hit,
    output logic                   full
);

    localparam int CW = (LOAD_LAT < 2) ? 1 : $clog2(LOAD_LAT + 1);
    localparam logic [CW-1:0] LAT_INIT = CW'(LOAD_LAT);

    if (DEPTH < LOAD_LAT || DEPTH < 1) begin : g_depth_check
        $error("load_scoreboard: DEPTH (%0d) must be >= LOAD_LAT (%0d) and >= 1",
               DEPTH, LOAD_LAT);
    end

    logic [DEPTH-1:0]  valid;
    logic [ADDR_W-1:0] addr [DEPTH];
    logic [CW-1:0]     cnt  [DEPTH];

    logic [DEPTH-1:0] expire;
    logic [DEPTH-1:0] free_now;
    logic [DEPTH-1:0] alloc_onehot;
    logic [NSRC-1:0]  src_hit;
    logic             need;
    logic             do_alloc;

    for (genvar s = 0; s < NSRC; s++) begin : g_src
        logic [ADDR_W-1:0] a;
        logic [DEPTH-1:0]  m;
        assign a = src_addr[s*ADDR_W +: ADDR_W];
        for (genvar e = 0; e < DEPTH; e++) begin : g_ent
            assign m[e] = valid[e] && (addr[e] == a);
        end
        assign src_hit[s] = src_use[s] && (|m) && !((ZERO_HW != 0) && (a == '0));
    end

    assign hit = |src_hit;

    assign need = req_valid && (LOAD_LAT > 0) && !((ZERO_HW != 0) && (wb_addr == '0));
    // Fullness looks at the registered valids: an entry retiring this cycle
    // does not prevent the stall, it only becomes reusable for allocation.
    assign full = need && (&valid);

    for (genvar e = 0; e < DEPTH; e++) begin : g_free
        assign expire[e]   = valid[e] && (cnt[e] == CW'(1));
        assign free_now[e] = !valid[e] || (advance && expire[e]);
    end

    // Isolate the lowest set bit to pick the lowest-index free entry.
    assign alloc_onehot = free_now & (~free_now + DEPTH'(1));
    assign do_alloc     = alloc_en && need;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (do_alloc && alloc_onehot[e]) begin
                    valid[e] <= 1'b1;
                end else if (advance && expire[e]) begin
                    valid[e] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int e = 0; e < DEPTH; e++) begin
            if (do_alloc && alloc_onehot[e]) begin
                addr[e] <= wb_addr;
                cnt[e]  <= LAT_INIT;
            end else if (advance && valid[e] && !expire[e]) begin
                cnt[e] <= cnt[e] - CW'(1);
            end
        end
    end

endmodule

// File: rtl/hazard_pause_ctrl.sv
// Pipeline pause/flush controller: arbitrates EX busy, branch flush and
// load-use hazards, and counts PC-hold cycles for performance debug.
module hazard_pause_ctrl
    import hazard_pause_ctrl_pkg::*;
#(
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int NSRC     = 2,
    parameter int LOAD_LAT = 1,
    parameter int DEPTH    = 2,
    parameter int ZERO_HW  = 1,
    parameter int CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [NSRC*ADDR_W-1:0] id_src_addr,
    input  logic [NSRC-1:0]        id_src_use,
    input  logic                   id_is_load,
    input  logic                   id_wb_en,
    input  logic [ADDR_W-1:0]      id_wb_addr,
    input  logic                   ex_busy,
    input  logic                   branch_flush,
    output logic                   pc_pause,
    output logic                   ii_pause,
    output logic                   ie_pause,
    output logic                   ie_bubble,
    output logic                   ii_flush,
    output logic [CNT_W-1:0]       stall_cnt
);

    logic        advance;
    logic        hit;
    logic        full;
    logic        alloc_en;
    pause_mode_t mode;

    assign advance = !ex_busy;

    always_comb begin
        mode = MODE_RUN;
        if (ex_busy) begin
            mode = MODE_BUSY;
        end else if (branch_flush) begin
            mode = MODE_FLUSH;
        end else if (id_valid && (hit || full)) begin
            mode = MODE_LOAD_USE;
        end
    end

    // Only a cleanly issuing instruction may claim an entry; busy, flush and
    // load-use cycles all keep the ID instruction from entering EX.
    assign alloc_en = (mode == MODE_RUN);

    load_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NSRC     (NSRC),
        .LOAD_LAT (LOAD_LAT),
        .DEPTH    (DEPTH),
        .ZERO_HW  (ZERO_HW)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .advance   (advance),
        .alloc_en  (alloc_en),
        .req_valid (id_valid && id_is_load && id_wb_en),
        .wb_addr   (id_wb_addr),
        .src_addr  (id_src_addr),
        .src_use   (id_src_use),
        .hit       (hit),
        .full      (full)
    );

    always_comb begin
        pc_pause  = PAUSE_DISABLE;
        ii_pause  = PAUSE_DISABLE;
        ie_pause  = PAUSE_DISABLE;
        ie_bubble = PAUSE_DISABLE;
        ii_flush  = PAUSE_DISABLE;
        if (rst_n) begin
            case (mode)
                MODE_BUSY: begin
                    pc_pause = PAUSE_ENABLE;
                    ii_pause = PAUSE_ENABLE;
                    ie_pause = PAUSE_ENABLE;
                end
                MODE_FLUSH: begin
                    ii_flush  = PAUSE_ENABLE;
                    ie_bubble = PAUSE_ENABLE;
                end
                MODE_LOAD_USE: begin
                    pc_pause  = PAUSE_ENABLE;
                    ii_pause  = PAUSE_ENABLE;
                    ie_bubble = PAUSE_ENABLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (pc_pause && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_pause_ctrl.sv
// Scenario bench for hazard_pause_ctrl across three parameter sets sharing one
// stimulus bus; expected control words are queued with stimulus and checked.
module tb_hazard_pause_ctrl;

    localparam logic [4:0] C_RUN   = 5'b00000;
    localparam logic [4:0] C_BUSY  = 5'b11100;
    localparam logic [4:0] C_FLUSH = 5'b00011;
    localparam logic [4:0] C_LU    = 5'b11010;

    typedef struct packed {
        logic       rn;
        logic       v;
        logic [2:0] a;
        logic [2:0] b;
        logic [1:0] su;
        logic       ld;
        logic       we;
        logic [2:0] wa;
        logic       busy;
        logic       fl;
    } stim_t;

    typedef struct packed {
        logic [4:0]  ctl;
        logic        chk;
        logic [15:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [5:0] id_src_addr;
    logic [1:0] id_src_use;
    logic       id_is_load;
    logic       id_wb_en;
    logic [2:0] id_wb_addr;
    logic       ex_busy;
    logic       branch_flush;

    logic pc_a, ii_a, iep_a, bub_a, fl_a;
    logic pc_b, ii_b, iep_b, bub_b, fl_b;
    logic pc_c, ii_c, iep_c, bub_c, fl_c;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;
    logic [15:0] cnt_c;
    logic [4:0]  ctl_a, ctl_b, ctl_c;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    assign ctl_a = {pc_a, ii_a, iep_a, bub_a, fl_a};
    assign ctl_b = {pc_b, ii_b, iep_b, bub_b, fl_b};
    assign ctl_c = {pc_c, ii_c, iep_c, bub_c, fl_c};

    // Default configuration: LOAD_LAT=1, DEPTH=2, CNT_W=16.
    hazard_pause_ctrl #(.ADDR_W(3), .NSRC(2), .LOAD_LAT(1), .DEPTH(2), .ZERO_HW(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_src_use(id_src_use), .id_is_load(id_is_load), .id_wb_en(id_wb_en),
        .id_wb_addr(id_wb_addr), .ex_busy(ex_busy), .branch_flush(branch_flush),
        .pc_pause(pc_a), .ii_pause(ii_a), .ie_pause(iep_a), .ie_bubble(bub_a),
        .ii_flush(fl_a), .stall_cnt(cnt_a));

    // Two-cycle load latency with a narrow counter for saturation.
    hazard_pause_ctrl #(.ADDR_W(3), .NSRC(2), .LOAD_LAT(2), .DEPTH(2), .ZERO_HW(1), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_src_use(id_src_use), .id_is_load(id_is_load), .id_wb_en(id_wb_en),
        .id_wb_addr(id_wb_addr), .ex_busy(ex_busy), .branch_flush(branch_flush),
        .pc_pause(pc_b), .ii_pause(ii_b), .ie_pause(iep_b), .ie_bubble(bub_b),
        .ii_flush(fl_b), .stall_cnt(cnt_b));

    // Single-entry scoreboard to exercise the full condition.
    hazard_pause_ctrl #(.ADDR_W(3), .NSRC(2), .LOAD_LAT(1), .DEPTH(1), .ZERO_HW(1), .CNT_W(16)) dut_c (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_src_use(id_src_use), .id_is_load(id_is_load), .id_wb_en(id_wb_en),
        .id_wb_addr(id_wb_addr), .ex_busy(ex_busy), .branch_flush(branch_flush),
        .pc_pause(pc_c), .ii_pause(ii_c), .ie_pause(iep_c), .ie_bubble(bub_c),
        .ii_flush(fl_c), .stall_cnt(cnt_c));

    function automatic stim_t mk(input logic rn, input logic v, input logic [2:0] a,
                                 input logic [2:0] b, input logic [1:0] su, input logic ld,
                                 input logic we, input logic [2:0] wa, input logic busy,
                                 input logic fl);
        stim_t s;
        s.rn = rn; s.v = v; s.a = a; s.b = b; s.su = su;
        s.ld = ld; s.we = we; s.wa = wa; s.busy = busy; s.fl = fl;
        return s;
    endfunction

    function automatic exp_t mk_e(input logic [4:0] ctl, input logic chk, input logic [15:0] cnt);
        exp_t e;
        e.ctl = ctl; e.chk = chk; e.cnt = cnt;
        return e;
    endfunction

    task automatic apply(input stim_t s);
        rst_n        = s.rn;
        id_valid     = s.v;
        id_src_addr  = {s.b, s.a};
        id_src_use   = s.su;
        id_is_load   = s.ld;
        id_wb_en     = s.we;
        id_wb_addr   = s.wa;
        ex_busy      = s.busy;
        branch_flush = s.fl;
    endtask

    task automatic do_reset();
        apply(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e;
        st.push_back(mk(0, 1, 3'd3, 0, 2'b01, 1, 1, 3'd3, 1, 0)); ex.push_back(mk_e(C_RUN, 1, 0));
        st.push_back(mk(0, 1, 3'd3, 0, 2'b01, 0, 0, 3'd0, 0, 1)); ex.push_back(mk_e(C_RUN, 1, 0));
        st.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));       ex.push_back(mk_e(C_RUN, 1, 0));
        st.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0));       ex.push_back(mk_e(C_BUSY, 0, 0));
        st.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));       ex.push_back(mk_e(C_RUN, 1, 1));
        foreach (st[i]) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (ctl_a !== e.ctl || ctl_b !== e.ctl || ctl_c !== e.ctl) begin
                bad++;
                $display("FAIL reset[%0d] ctl a=%b b=%b c=%b required=%b", i, ctl_a, ctl_b, ctl_c, e.ctl);
            end
            if (e.chk) begin
                total++;
                if (cnt_a !== e.cnt || cnt_c !== e.cnt) begin
                    bad++;
                    $display("FAIL reset_cnt[%0d] a=%0d c=%0d required=%0d", i, cnt_a, cnt_c, e.cnt);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e;
        do_reset();
        st.push_back(mk(1, 1, 0, 0, 2'b00, 1, 1, 3'd3, 0, 0)); ex.push_back(mk_e(C_RUN, 0, 0));
        st.push_back(mk(1, 1, 3'd3, 0, 2'b01, 0, 0, 0, 0, 0)); ex.push_back(mk_e(C_LU, 0, 0));
        st.push_back(mk(1, 1, 3'd3, 0, 2'b01, 0, 0, 0, 0, 0)); ex.push_back(mk_e(C_RUN, 1, 1));
        foreach (st[i]) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (ctl_a !== e.ctl) begin
                bad++;
                $display("FAIL load_use[%0d] ctl=%b required=%b", i, ctl_a, e.ctl);
            end
            if (e.chk) begin
                total++;
                if (cnt_a !== e.cnt) begin
                    bad++;
                    $display("FAIL load_use_cnt[%0d] got=%0d required=%0d", i, cnt_a, e.cnt);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lat2();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e;
        do_reset();
        st.push_back(mk(1, 1, 0, 0, 2'b00, 1, 1, 3'd5, 0, 0)); ex.push_back(mk_e(C_RUN, 0, 0));
        st.push_back(mk(1, 1, 0, 3'd5, 2'b10, 0, 0, 0, 0, 0)); ex.push_back(mk_e(C_LU, 0, 0));
        st.push_back(mk(1, 1, 0, 3'd5, 2'b10, 0, 0, 0, 0, 0)); ex.push_back(mk_e(C_LU, 0, 0));
        st.push_back(mk(1, 1, 0, 3'd5, 2'b10, 0, 0, 0, 0, 0)); ex.push_back(mk_e(C_RUN, 1, 2));
        st.push_back(mk(1, 1, 0, 0, 2'b00, 1, 1, 3'd5, 0, 0)); ex.push_back(mk_e(C_RUN, 0, 0));
        st.push_back(mk(1, 1, 3'd5, 3'd5, 2'b00, 0, 0, 0, 0, 0)); ex.push_back(mk_e(C_RUN, 0, 0));
        st.push_back(mk(1, 1, 3'd5, 3'd5, 2'b00, 0, 0, 0, 0, 0)); ex.push_back(mk_e(C_RUN, 1, 2));
        foreach (st[i]) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (ctl_b !== e.ctl) begin
                bad++;
                $display("FAIL lat2[%0d] ctl=%b required=%b", i, ctl_b, e.ctl);
            end
            if (e.chk) begin
                total++;
                if (cnt_b !== e.cnt[3:0]) begin
                    bad++;
                    $display("FAIL lat2_cnt[%0d] got=%0d required=%0d", i, cnt_b, e.cnt);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_busy();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e;
        do_reset();
        st.push_back(mk(1, 1, 0, 0, 2'b00, 1, 1, 3'd3, 0, 0)); ex.push_back(mk_e(C_RUN, 0, 0));
        for (int k = 0; k < 3; k++) begin
            st.push_back(mk(1, 1, 3'd3, 0, 2'b01, 0, 0, 0, 1, 0)); ex.push_back(mk_e(C_BUSY, 0, 0));
        end
        st.push_back(mk(1, 1, 3'd3, 0, 2'b01, 0, 0, 0, 0, 0)); ex.push_back(mk_e(C_LU, 0, 0));
        st.push_back(mk(1, 1, 3'd3, 0, 2'b01, 0, 0, 0, 0, 0)); ex.push_back(mk_e(C_RUN, 1, 4));
        foreach (st[i]) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (ctl_a !== e.ctl) begin
                bad++;
                $display("FAIL busy[%0d] ctl=%b required=%b", i, ctl_a, e.ctl);
            end
            if (e.chk) begin
                total++;
                if (cnt_a !== e.cnt) begin
                    bad++;
                    $display("FAIL busy_cnt[%0d] got=%0d required=%0d", i, cnt_a, e.cnt);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e;
        do_reset();
        st.push_back(mk(1, 1, 0, 0, 2'b00, 1, 1, 3'd3, 0, 0)); ex.push_back(mk_e(C_RUN, 0, 0));
        st.push_back(mk(1, 1, 3'd3, 0, 2'b01, 0, 0, 0, 0, 1)); ex.push_back(mk_e(C_FLUSH, 0, 0));
        st.push_back(mk(1, 1, 3'd3, 0, 2'b01, 0, 0, 0, 0, 0)); ex.push_back(mk_e(C_RUN, 0, 0));
        st.push_back(mk(1, 1, 0, 0, 2'b00, 1, 1, 3'd3, 0, 0)); ex.push_back(mk_e(C_RUN, 0, 0));
        st.push_back(mk(1, 1, 3'd3, 0, 2'b01, 0, 0, 0, 1, 1)); ex.push_back(mk_e(C_BUSY, 0, 0));
        st.push_back(mk(1, 1, 3'd3, 0, 2'b01, 0, 0, 0, 0, 0)); ex.push_back(mk_e(C_LU, 0, 0));
        st.push_back(mk(1, 1, 3'd3, 0, 2'b01, 0, 0, 0, 0, 0)); ex.push_back(mk_e(C_RUN, 1, 2));
        st.push_back(mk(1, 1, 0, 0, 2'b00, 1, 1, 3'd4, 0, 1)); ex.push_back(mk_e(C_FLUSH, 0, 0));
        st.push_back(mk(1, 1, 3'd4, 3'd4, 2'b11, 0, 0, 0, 0, 0)); ex.push_back(mk_e(C_RUN, 1, 2));
        foreach (st[i]) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (ctl_a !== e.ctl) begin
                bad++;
                $display("FAIL flush[%0d] ctl=%b required=%b", i, ctl_a, e.ctl);
            end
            if (e.chk) begin
                total++;
                if (cnt_a !== e.cnt) begin
                    bad++;
                    $display("FAIL flush_cnt[%0d] got=%0d required=%0d", i, cnt_a, e.cnt);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_zero_full();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e;
        do_reset();
        st.push_back(mk(1, 1, 0, 0, 2'b00, 1, 1, 3'd0, 0, 0)); ex.push_back(mk_e(C_RUN, 0, 0));
        st.push_back(mk(1, 1, 3'd0, 3'd0, 2'b11, 1, 1, 3'd1, 0, 0)); ex.push_back(mk_e(C_RUN, 0, 0));
        st.push_back(mk(1, 1, 0, 0, 2'b00, 1, 1, 3'd2, 0, 0)); ex.push_back(mk_e(C_LU, 0, 0));
        st.push_back(mk(1, 1, 0, 0, 2'b00, 1, 1, 3'd2, 0, 0)); ex.push_back(mk_e(C_RUN, 0, 0));
        st.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 3'd0, 0, 0)); ex.push_back(mk_e(C_RUN, 1, 1));
        foreach (st[i]) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (ctl_c !== e.ctl) begin
                bad++;
                $display("FAIL zero_full[%0d] depth1 ctl=%b required=%b", i, ctl_c, e.ctl);
            end
            total++;
            if (ctl_a !== C_RUN) begin
                bad++;
                $display("FAIL zero_full[%0d] depth2 ctl=%b required=%b", i, ctl_a, C_RUN);
            end
            if (e.chk) begin
                total++;
                if (cnt_c !== e.cnt) begin
                    bad++;
                    $display("FAIL zero_full_cnt[%0d] got=%0d required=%0d", i, cnt_c, e.cnt);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturate_reset();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e;
        do_reset();
        st.push_back(mk(1, 1, 0, 0, 2'b00, 1, 1, 3'd5, 0, 0)); ex.push_back(mk_e(C_RUN, 0, 0));
        for (int k = 1; k <= 19; k++) begin
            st.push_back(mk(1, 1, 0, 3'd5, 2'b10, 0, 0, 0, 1, 0));
            ex.push_back(mk_e(C_BUSY, (k == 10 || k >= 16), (k == 10) ? 16'd9 : 16'd15));
        end
        st.push_back(mk(1, 1, 0, 3'd5, 2'b10, 0, 0, 0, 0, 0)); ex.push_back(mk_e(C_LU, 1, 15));
        st.push_back(mk(0, 1, 0, 3'd5, 2'b10, 0, 0, 0, 0, 0)); ex.push_back(mk_e(C_RUN, 1, 15));
        st.push_back(mk(1, 1, 0, 3'd5, 2'b10, 0, 0, 0, 0, 0)); ex.push_back(mk_e(C_RUN, 1, 0));
        st.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));    ex.push_back(mk_e(C_RUN, 1, 0));
        foreach (st[i]) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (ctl_b !== e.ctl) begin
                bad++;
                $display("FAIL saturate[%0d] ctl=%b required=%b", i, ctl_b, e.ctl);
            end
            if (e.chk) begin
                total++;
                if (cnt_b !== e.cnt[3:0]) begin
                    bad++;
                    $display("FAIL saturate_cnt[%0d] got=%0d required=%0d", i, cnt_b, e.cnt);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_lat2();
        test_busy();
        test_flush();
        test_zero_full();
        test_saturate_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_pause_ctrl.md
Name: hazard_pause_ctrl

Overview:
- Parametrised successor to the single-cycle pause logic of the 5-stage core.
- Tracks in-flight loads in a small countdown scoreboard, so load-to-use latency is a parameter instead of a fixed single bubble.
- Also arbitrates multi-cycle EX busy and branch flush.
- Drives PC, IF/ID and ID/EX hold, bubble and flush controls, and keeps a saturating stall-cycle counter for performance debug.

Parameters:
- ADDR_W, 3: register address width.
- NSRC, 2: number of source operands checked per ID instruction.
- LOAD_LAT, 1: bubbles required between a load and its first consumer. 0 means loads never stall.
- DEPTH, 2: scoreboard entries. Must be >= LOAD_LAT; elaboration error otherwise.
- ZERO_HW, 1: when 1, register address 0 never creates a hazard and is never allocated.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- id_valid  in  1  ID stage holds a real instruction
- id_src_addr  in  NSRC*ADDR_W  source register addresses; operand i sits at bits [i*ADDR_W +: ADDR_W]
- id_src_use  in  NSRC  operand i is actually read (ALU A/B select is a register)
- id_is_load  in  1  ID instruction is a load
- id_wb_en  in  1  ID instruction writes the register file
- id_wb_addr  in  ADDR_W  ID destination register
- ex_busy  in  1  multi-cycle EX unit not done
- branch_flush  in  1  EX resolved a taken branch/jump this cycle
- pc_pause  out  1  hold PC
- ii_pause  out  1  hold IF/ID register
- ie_pause  out  1  hold ID/EX register
- ie_bubble  out  1  load a NOP into ID/EX
- ii_flush  out  1  clear IF/ID to NOP
- stall_cnt  out  CNT_W  saturating count of pc_pause cycles

Behaviour:
- State:
  - DEPTH entries, each {valid, addr[ADDR_W], cnt}.
  - stall_cnt.
- Control outputs:
  - Combinational from the registered state plus current inputs.
  - Forced to 0 while rst_n=0.
- Reset (rst_n=0 at a clk edge): all entries invalid; stall_cnt=0.
- advance = !ex_busy.
- hit:
  - True when any operand i with id_src_use[i]=1 matches a valid entry addr.
  - If ZERO_HW=1, an operand with address 0 never hits.
  - Match is on registered cnt >= 1, i.e. pre-decrement. An entry at cnt=1 still stalls this cycle.
- full:
  - No free entry, while the ID instruction needs one.
  - The ID instruction needs an entry when: id_valid & id_is_load & id_wb_en & LOAD_LAT>0 & !(ZERO_HW & id_wb_addr==0).
- Priority, exactly one mode per cycle:
  1. BUSY (ex_busy=1): pc_pause=ii_pause=ie_pause=1, ie_bubble=0, ii_flush=0. branch_flush is ignored this cycle; its source must hold it. Scoreboard frozen: no decrement, no allocation.
  2. FLUSH (branch_flush=1): ii_flush=1, ie_bubble=1, all pauses 0. The ID instruction is squashed and not allocated. Existing entries decrement.
  3. LOAD_USE (id_valid & (hit | full)): pc_pause=ii_pause=1, ie_pause=0, ie_bubble=1. No allocation. Entries decrement.
  4. RUN: all outputs 0. Entries decrement. Allocate if the ID instruction needs an entry.
- Decrement rule:
  - Applies on every advance cycle.
  - Valid entry with cnt>1: cnt-1.
  - Valid entry with cnt==1: becomes invalid.
- Allocation:
  - Lowest-index free entry, counting entries freed this same cycle as free.
  - Written as addr=id_wb_addr, cnt=LOAD_LAT.
  - A duplicate destination gets its own entry; both entries match.
- Latency: a load issued in cycle t followed by a dependent in ID gives exactly LOAD_LAT cycles of LOAD_USE, then the dependent issues.
- stall_cnt: +1 on each cycle with pc_pause=1; holds at all-ones; unaffected by flush.
- Reset mid-stall: next cycle is RUN with an empty scoreboard.

Decomposition:
- Shared package/define file:
  - PAUSE_ENABLE/PAUSE_DISABLE constants.
  - Default ADDR_W.
  - Mode encoding (BUSY, FLUSH, LOAD_USE, RUN) for debug visibility.
- One sub-module: load_scoreboard.
  - Holds the entries, match, free/allocate and decrement logic.
  - Outputs hit and full.
  - Top level does priority, the output decode and stall_cnt.

Test Plan:
1. LOAD_LAT=1: load to r3 issues, next ID reads r3 on operand A -> one cycle pc_pause=ii_pause=ie_bubble=1, then RUN; stall_cnt=1.
2. LOAD_LAT=2, DEPTH=2: load r5, dependent reads r5 on operand B -> 2 LOAD_USE cycles. The same case with id_src_use[1]=0 -> no stall.
3. ex_busy high 3 cycles during a pending load (cnt=1) -> 3 BUSY cycles with all pauses 1, entry still cnt=1, then 1 LOAD_USE cycle.
4. branch_flush with a dependent in ID -> ii_flush=ie_bubble=1 and no pause. The same cycle with ex_busy=1 -> BUSY outputs, flush ignored.
5. ZERO_HW=1: load r0 followed by a read of r0 -> no allocation, no stall. Two back-to-back loads with DEPTH=1, LOAD_LAT=1 -> second load sees full and stalls 1 cycle.
6. Force 2^CNT_W+3 stall cycles with CNT_W=4 -> stall_cnt saturates at 15. rst_n=0 during LOAD_USE -> outputs 0, scoreboard empty and stall_cnt=0 after the edge.
